// File: rtl/mem_access_unit.sv
// MEM stage access unit: drives a req/ack data-memory bus, stalls EX/MEM while busy, fills MEM/WB.
// Define MEM_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT_CYCLES busy cycles.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [3:0]  Rd_in,
  input  logic        reg_write_en_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic        mem_to_reg_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [3:0]  wb_Rd,
  output logic [31:0] wb_data,
  output logic        wb_reg_write_en,
  output logic        mem_fault
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic mem_op;
  logic aligned;
  logic timeout_hit;

  assign mem_op  = mem_read_en_in | mem_write_en_in;
  assign aligned = (alu_result_in[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt;
  // Terminal busy cycle: this is the last ack-less cycle we are willing to wait.
  assign timeout_hit = (state == BUSY) && !dmem_ack &&
                       (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // The instruction is released in the same cycle the bus completes or aborts.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (state == IDLE) stall = mem_op & aligned;
      else               stall = !dmem_ack && !timeout_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_wdata      <= 32'd0;
      wb_valid        <= 1'b0;
      wb_pc           <= 32'd0;
      wb_Rd           <= 4'd0;
      wb_data         <= 32'd0;
      wb_reg_write_en <= 1'b0;
      mem_fault       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout_cnt     <= '0;
`endif
    end else begin
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op || !aligned) begin
            wb_valid        <= 1'b1;
            wb_pc           <= pc_in;
            wb_Rd           <= Rd_in;
            wb_data         <= alu_result_in;
            wb_reg_write_en <= mem_op ? 1'b0 : reg_write_en_in;
            mem_fault       <= mem_op;
          end else begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_en_in;
            dmem_addr  <= alu_result_in;
            dmem_wdata <= write_data_in;
`ifdef MEM_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (dmem_ack || timeout_hit) begin
            state           <= IDLE;
            dmem_req        <= 1'b0;
            wb_valid        <= 1'b1;
            wb_pc           <= pc_in;
            wb_Rd           <= Rd_in;
            wb_data         <= (dmem_ack && mem_to_reg_in) ? dmem_rdata : alu_result_in;
            wb_reg_write_en <= dmem_ack ? reg_write_en_in : 1'b0;
            mem_fault       <= !dmem_ack;
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/ack/timeout sequences, random transactions.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TO     = 4;
  localparam int ST_DLY = 2;
  localparam int MAXDLY = 3;
`else
  localparam int TO     = 8;
  localparam int ST_DLY = 4;
  localparam int MAXDLY = 6;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc_in, alu_result_in, write_data_in;
  logic [3:0]  Rd_in;
  logic        reg_write_en_in, mem_read_en_in, mem_write_en_in, mem_to_reg_in;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [3:0]  wb_Rd;
  logic [31:0] wb_data;
  logic        wb_reg_write_en, mem_fault;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .Rd_in(Rd_in), .reg_write_en_in(reg_write_en_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .mem_to_reg_in(mem_to_reg_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_Rd(wb_Rd),
    .wb_data(wb_data), .wb_reg_write_en(wb_reg_write_en), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc, alu, wd;
    logic [3:0]  rd;
    logic        rwe, mre, mwe, m2r;
    int          dly;
    logic [31:0] rdata;
    int          exp_stall;
    logic        exp_bus, exp_we;
    logic [31:0] exp_data;
    logic        exp_rwe, exp_fault;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] pc, alu, wd, input logic [3:0] rd,
                              input logic rwe, mre, mwe, m2r, input int dly,
                              input logic [31:0] rdata, input int es, input logic eb, ewe,
                              input logic [31:0] edata, input logic erwe, efault);
    txn_t t;
    t.pc = pc; t.alu = alu; t.wd = wd; t.rd = rd;
    t.rwe = rwe; t.mre = mre; t.mwe = mwe; t.m2r = m2r;
    t.dly = dly; t.rdata = rdata;
    t.exp_stall = es; t.exp_bus = eb; t.exp_we = ewe;
    t.exp_data = edata; t.exp_rwe = erwe; t.exp_fault = efault;
    return t;
  endfunction

  // Reference rules: memory ops need a word address, stall until ack, return load data if selected.
  function automatic txn_t model(input txn_t t);
    txn_t r;
    logic memop;
    r = t;
    memop       = t.mre | t.mwe;
    r.exp_bus   = memop && (t.alu % 4 == 0);
    r.exp_we    = t.mwe;
    r.exp_fault = memop && !r.exp_bus;
    r.exp_stall = r.exp_bus ? 1 + t.dly : 0;
    r.exp_data  = (r.exp_bus && t.m2r) ? t.rdata : t.alu;
    r.exp_rwe   = r.exp_fault ? 1'b0 : t.rwe;
    return r;
  endfunction

  task automatic drive(input txn_t t);
    pc_in = t.pc; alu_result_in = t.alu; write_data_in = t.wd; Rd_in = t.rd;
    reg_write_en_in = t.rwe; mem_read_en_in = t.mre; mem_write_en_in = t.mwe;
    mem_to_reg_in = t.m2r;
  endtask

  task automatic do_txn(input txn_t t, input string tag);
    drive(t);
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    #1;
    chk({tag, ".stall_first"}, 32'(stall), 32'(t.exp_stall > 0));
    @(posedge clk); #1;
    if (t.exp_bus) begin
      for (int b = 0; b <= t.dly; b++) begin
        chk({tag, ".req"}, 32'(dmem_req), 32'd1);
        chk({tag, ".we"}, 32'(dmem_we), 32'(t.exp_we));
        chk({tag, ".addr"}, dmem_addr, t.alu);
        chk({tag, ".wdata"}, dmem_wdata, t.wd);
        chk({tag, ".busy_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, ".busy_fault"}, 32'(mem_fault), 32'd0);
        if (b == t.dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = t.rdata;
        end
        #1;
        chk({tag, ".stall_busy"}, 32'(stall), 32'(b < t.dly));
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
    chk({tag, ".req_done"}, 32'(dmem_req), 32'd0);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_pc"}, wb_pc, t.pc);
    chk({tag, ".wb_rd"}, 32'(wb_Rd), 32'(t.rd));
    chk({tag, ".wb_data"}, wb_data, t.exp_data);
    chk({tag, ".wb_rwe"}, 32'(wb_reg_write_en), 32'(t.exp_rwe));
    chk({tag, ".fault"}, 32'(mem_fault), 32'(t.exp_fault));
  endtask

  txn_t vec[8];
  txn_t tr;

  initial begin
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.valid", 32'(wb_valid), 32'd0);
    chk("rst.pc", wb_pc, 32'd0);
    chk("rst.rd", 32'(wb_Rd), 32'd0);
    chk("rst.data", wb_data, 32'd0);
    chk("rst.rwe", 32'(wb_reg_write_en), 32'd0);
    chk("rst.fault", 32'(mem_fault), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //           pc        alu           wd            rd rwe mre mwe m2r dly     rdata         stall      bus we data          rwe flt
    vec[0] = mk(32'h1000, 32'h1234,     32'h0,        3, 1, 0, 0, 0, 0,      32'h0,        0,         0, 0, 32'h1234,     1, 0);
    vec[1] = mk(32'h1004, 32'h100,      32'h0,        5, 1, 1, 0, 1, 0,      32'hDEADBEEF, 1,         1, 0, 32'hDEADBEEF, 1, 0);
    vec[2] = mk(32'h1008, 32'h200,      32'hA5A5A5A5, 0, 0, 0, 1, 0, ST_DLY, 32'h0,        1 + ST_DLY, 1, 1, 32'h200,      0, 0);
    vec[3] = mk(32'h100C, 32'h102,      32'h0,        6, 1, 1, 0, 1, 0,      32'h0,        0,         0, 0, 32'h102,      0, 1);
    vec[4] = mk(32'h1010, 32'hCAFE0000, 32'h0,        7, 1, 0, 0, 0, 0,      32'h0,        0,         0, 0, 32'hCAFE0000, 1, 0);
    vec[5] = mk(32'h1014, 32'h300,      32'h11223344, 8, 0, 1, 1, 0, 1,      32'h0,        2,         1, 1, 32'h300,      0, 0);
    vec[6] = mk(32'h1018, 32'h404,      32'h0,        9, 1, 1, 0, 0, 2,      32'h55555555, 3,         1, 0, 32'h404,      1, 0);
    vec[7] = mk(32'h101C, 32'h203,      32'h77,       2, 0, 0, 1, 0, 0,      32'h0,        0,         0, 1, 32'h203,      0, 1);
    for (int i = 0; i < 8; i++) do_txn(vec[i], $sformatf("vec%0d", i));

    // Ack while idle must not create a bus cycle.
    drive(mk(32'h2000, 32'h40, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("idle_ack.req", 32'(dmem_req), 32'd0);
    chk("idle_ack.data", wb_data, 32'h40);
    chk("idle_ack.valid", 32'(wb_valid), 32'd1);

    // Reset in the middle of a bus cycle, then a late ack.
    drive(mk(32'h3000, 32'h500, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("midrst.req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.addr", dmem_addr, 32'd0);
    chk("midrst.valid", 32'(wb_valid), 32'd0);
    chk("midrst.data", wb_data, 32'd0);
    drive(mk(32'h3004, 32'h77, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("lateack.req", 32'(dmem_req), 32'd0);
    chk("lateack.fault", 32'(mem_fault), 32'd0);
    chk("lateack.data", wb_data, 32'h77);

`ifdef MEM_TIMEOUT_EN
    drive(mk(32'h4000, 32'h400, 0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("to.stall_first", 32'(stall), 32'd1);
    @(posedge clk); #1;
    for (int b = 0; b < TO; b++) begin
      chk("to.req", 32'(dmem_req), 32'd1);
      #1;
      chk("to.stall", 32'(stall), 32'(b < TO - 1));
      @(posedge clk); #1;
    end
    chk("to.req_drop", 32'(dmem_req), 32'd0);
    chk("to.fault", 32'(mem_fault), 32'd1);
    chk("to.valid", 32'(wb_valid), 32'd1);
    chk("to.rwe", 32'(wb_reg_write_en), 32'd0);
    drive(mk(32'h4004, 32'h8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("to.fault_clear", 32'(mem_fault), 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      tr = mk($urandom, $urandom, $urandom, 4'($urandom), 1'($urandom), 0, 0, 1'($urandom),
              int'($urandom_range(0, MAXDLY)), $urandom, 0, 0, 0, 0, 0, 0);
      case ($urandom_range(0, 3))
        0: ;
        1: begin tr.mre = 1'b1; tr.alu[1:0] = 2'b00; end
        2: begin tr.mwe = 1'b1; tr.mre = 1'($urandom); tr.alu[1:0] = 2'b00; end
        default: begin
          tr.mre = 1'($urandom); tr.mwe = !tr.mre;
          tr.alu[1:0] = 2'($urandom_range(1, 3));
        end
      endcase
      do_txn(model(tr), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
